// File: rtl/trap_ctrl_if.sv
// Fetch redirect handshake: the trap sequencer requests a new PC, fetch acknowledges with ready.
interface trap_ctrl_if;
    logic        REDIRECT_VALID_SM;
    logic [31:0] REDIRECT_PC_SM;
    logic        REDIRECT_READY_SI;

    modport master (
        output REDIRECT_VALID_SM,
        output REDIRECT_PC_SM,
        input  REDIRECT_READY_SI
    );

    modport slave (
        input  REDIRECT_VALID_SM,
        input  REDIRECT_PC_SM,
        output REDIRECT_READY_SI
    );
endinterface

// File: rtl/trap_ctrl.sv
// Trap sequencer beside M: takes irq/sync exception/MRET, writes CSR trap data and redirects fetch.
// Strobe and redirect one cycle after detect; M stays stalled and F/D/E flushed until fetch accepts.
module trap_ctrl #(
    parameter bit VECTORED_EN     = 1'b1,
    parameter bit MTVAL_ILL_INSTR = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        VALID_SM,
    input  logic [31:0] PC_SM,
    input  logic [31:0] INSTR_SM,
    input  logic [31:0] BADADR_SM,
    input  logic        EXC_IMIS_SM,
    input  logic        EXC_ILL_SM,
    input  logic        EXC_EBRK_SM,
    input  logic        EXC_ECALL_SM,
    input  logic        EXC_LMIS_SM,
    input  logic        EXC_SMIS_SM,
    input  logic        MRET_SM,

    input  logic        MEIP_I,
    input  logic        MTIP_I,
    input  logic        MSIP_I,

    input  logic [31:0] MSTATUS_RC,
    input  logic [31:0] MIE_VALUE_RC,
    input  logic [31:0] MTVEC_VALUE_RC,
    input  logic [31:0] MEPC_SC,

    input  logic        CSR_ENABLE_SM,
    input  logic [11:0] CSR_WADR_SM,
    input  logic [31:0] CSR_WDATA_SM,

    output logic        KILL_SM,
    output logic        EXCEPTION_SM,
    output logic [31:0] MSTATUS_WDATA_SM,
    output logic [31:0] MIP_WDATA_SM,
    output logic [31:0] MEPC_WDATA_SM,
    output logic [31:0] MCAUSE_WDATA_SM,
    output logic [31:0] MTVAL_WDATA_SM,
    output logic        FLUSH_SM,
    output logic        BUSY_SM,

    trap_ctrl_if.master redir
);

    localparam logic [11:0] CSR_MTVAL = 12'h343;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMIT = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_strobe;
    logic [31:0] r_mstatus;
    logic [31:0] r_mip;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [31:0] r_redir_pc;
    logic [31:0] r_shadow;

    logic [31:0] w_pend;
    logic [31:0] w_irq_act;
    logic        w_irq;
    logic        w_exc;
    logic        w_idle;
    logic        w_take;
    logic [4:0]  w_irq_code;
    logic [31:0] w_cause;
    logic [31:0] w_mtval;
    logic [31:0] w_mst_trap;
    logic [31:0] w_mst_mret;
    logic [31:0] w_vec_base;
    logic [31:0] w_target;
    logic        w_redir_vld;
    logic        w_busy;

    // Pending lines sit at their mip bit positions so they can be masked by mie directly.
    assign w_pend    = {20'd0, MEIP_I, 3'd0, MTIP_I, 3'd0, MSIP_I, 3'd0};
    assign w_irq_act = w_pend & MIE_VALUE_RC;
    assign w_irq     = MSTATUS_RC[3] & (|w_irq_act);
    assign w_exc     = EXC_IMIS_SM | EXC_ILL_SM | EXC_EBRK_SM |
                       EXC_ECALL_SM | EXC_LMIS_SM | EXC_SMIS_SM;
    assign w_idle    = (r_state == S_IDLE);
    assign w_take    = w_idle & VALID_SM & (w_irq | w_exc | MRET_SM);

    always_comb begin
        w_irq_code = 5'd7;
        if (w_irq_act[11]) begin
            w_irq_code = 5'd11;
        end else if (w_irq_act[3]) begin
            w_irq_code = 5'd3;
        end

        w_cause = 32'd0;
        w_mtval = 32'd0;
        if (w_irq) begin
            w_cause = {1'b1, 26'd0, w_irq_code};
        end else if (EXC_IMIS_SM) begin
            w_cause = 32'd0;
            w_mtval = BADADR_SM;
        end else if (EXC_ILL_SM) begin
            w_cause = 32'd2;
            w_mtval = MTVAL_ILL_INSTR ? INSTR_SM : 32'd0;
        end else if (EXC_EBRK_SM) begin
            w_cause = 32'd3;
            w_mtval = PC_SM;
        end else if (EXC_ECALL_SM) begin
            w_cause = 32'd11;
        end else if (EXC_LMIS_SM) begin
            w_cause = 32'd4;
            w_mtval = BADADR_SM;
        end else if (EXC_SMIS_SM) begin
            w_cause = 32'd6;
            w_mtval = BADADR_SM;
        end
    end

    always_comb begin
        w_mst_trap         = MSTATUS_RC;
        w_mst_trap[7]      = MSTATUS_RC[3];
        w_mst_trap[3]      = 1'b0;
        w_mst_trap[12:11]  = 2'b11;

        w_mst_mret         = MSTATUS_RC;
        w_mst_mret[3]      = MSTATUS_RC[7];
        w_mst_mret[7]      = 1'b1;
        w_mst_mret[12:11]  = 2'b11;
    end

    // Only interrupts use the vectored offset; sync exceptions always go to the base.
    always_comb begin
        w_vec_base = {MTVEC_VALUE_RC[31:2], 2'b00};
        w_target   = MEPC_SC;
        if (w_irq || w_exc) begin
            w_target = w_vec_base;
            if (VECTORED_EN && w_irq && (MTVEC_VALUE_RC[1:0] == 2'b01)) begin
                w_target = w_vec_base + {w_cause[29:0], 2'b00};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_redir_vld = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_redir_vld = 1'b1;
                w_busy      = 1'b1;
                w_state_nxt = redir.REDIRECT_READY_SI ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                w_redir_vld = 1'b1;
                w_busy      = 1'b1;
                if (redir.REDIRECT_READY_SI) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Everything the commit cycle needs is captured at detect, so later input changes cannot leak in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_strobe   <= 1'b0;
            r_mstatus  <= 32'd0;
            r_mip      <= 32'd0;
            r_mepc     <= 32'd0;
            r_mcause   <= 32'd0;
            r_mtval    <= 32'd0;
            r_redir_pc <= 32'd0;
        end else begin
            r_strobe <= w_take;
            if (w_take) begin
                r_mip      <= w_pend;
                r_redir_pc <= w_target;
                if (w_irq || w_exc) begin
                    r_mstatus <= w_mst_trap;
                    r_mepc    <= PC_SM;
                    r_mcause  <= w_cause;
                    r_mtval   <= w_mtval;
                end else begin
                    r_mstatus <= w_mst_mret;
                    r_mepc    <= MEPC_SC;
                    r_mtval   <= r_shadow;
                end
            end
        end
    end

    // Shadow of mtval so MRET can rewrite it unchanged without a read port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow <= 32'd0;
        end else if (r_strobe) begin
            r_shadow <= r_mtval;
        end else if (w_idle && !w_take && CSR_ENABLE_SM && (CSR_WADR_SM == CSR_MTVAL)) begin
            r_shadow <= CSR_WDATA_SM;
        end
    end

    assign KILL_SM                 = w_take;
    assign EXCEPTION_SM            = r_strobe;
    assign MSTATUS_WDATA_SM        = r_mstatus;
    assign MIP_WDATA_SM            = r_mip;
    assign MEPC_WDATA_SM           = r_mepc;
    assign MCAUSE_WDATA_SM         = r_mcause;
    assign MTVAL_WDATA_SM          = r_mtval;
    assign FLUSH_SM                = w_busy;
    assign BUSY_SM                 = w_busy;
    assign redir.REDIRECT_VALID_SM = w_redir_vld;
    assign redir.REDIRECT_PC_SM    = r_redir_pc;

endmodule
